// File: rtl/presc_counter_bank.sv
// Bank of NCH independent event counters, each fed through a programmable prescaler.
// Outputs are registered; Sel or CfgCh values that address a missing channel are ignored.
module presc_counter_bank #(
    parameter int WIDTH = 64,
    parameter int NCH   = 2,
    parameter int PSW   = 3,
    parameter int SAT   = 0,
    localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 En,
    input  logic [SW-1:0]        Sel,
    input  logic [NCH-1:0]       Clr,
    input  logic                 CfgWe,
    input  logic [SW-1:0]        CfgCh,
    input  logic [PSW-1:0]       CfgDiv,
    output logic [NCH*WIDTH-1:0] Count,
    output logic [NCH-1:0]       Tick,
    output logic [NCH-1:0]       Ovf
);

    logic [WIDTH-1:0] cnt_q [NCH] = '{default: '0};
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [PSW-1:0]   pre_q [NCH] = '{default: '0};
    logic [PSW-1:0]   pre_d [NCH];
    logic [PSW-1:0]   div_q [NCH] = '{default: '0};
    logic [PSW-1:0]   div_d [NCH];
    logic [NCH-1:0]   tick_q = '0;
    logic [NCH-1:0]   tick_d;
    logic [NCH-1:0]   ovf_q = '0;
    logic [NCH-1:0]   ovf_d;

    logic [NCH-1:0]   ev;
    logic [NCH-1:0]   inc;
    logic [NCH-1:0]   cfg;

    always_comb begin
        ev  = '0;
        inc = '0;
        cfg = '0;
        for (int c = 0; c < NCH; c++) begin
            ev[c]  = En && (int'(Sel) == c) && !Clr[c];
            inc[c] = ev[c] && (pre_q[c] == div_q[c]);
            cfg[c] = CfgWe && (int'(CfgCh) == c);
        end
    end

    always_comb begin
        tick_d = '0;
        ovf_d  = ovf_q;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            pre_d[c] = pre_q[c];
            div_d[c] = div_q[c];

            if (ev[c]) begin
                pre_d[c] = inc[c] ? '0 : pre_q[c] + PSW'(1);
            end
            if (inc[c]) begin
                tick_d[c] = 1'b1;
                if (&cnt_q[c]) begin
                    ovf_d[c] = 1'b1;
                    cnt_d[c] = (SAT != 0) ? cnt_q[c] : '0;
                end else begin
                    cnt_d[c] = cnt_q[c] + WIDTH'(1);
                end
            end
            // The event above was judged against the old divisor; the write only restarts pre.
            if (cfg[c]) begin
                div_d[c] = CfgDiv;
                pre_d[c] = '0;
            end
            if (Clr[c]) begin
                cnt_d[c]  = '0;
                pre_d[c]  = '0;
                ovf_d[c]  = 1'b0;
                tick_d[c] = 1'b0;
            end
            if (Reset) begin
                cnt_d[c] = '0;
                pre_d[c] = '0;
                div_d[c] = '0;
            end
        end
        if (Reset) begin
            tick_d = '0;
            ovf_d  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        cnt_q  <= cnt_d;
        pre_q  <= pre_d;
        div_q  <= div_d;
        tick_q <= tick_d;
        ovf_q  <= ovf_d;
    end

    always_comb begin
        Count = '0;
        for (int c = 0; c < NCH; c++) begin
            Count[c*WIDTH +: WIDTH] = cnt_q[c];
        end
    end

    assign Tick = tick_q;
    assign Ovf  = ovf_q;

endmodule

// File: doc/presc_counter_bank.md
PRESC_COUNTER_BANK -- requirements
Module: presc_counter_bank

Parameters
REQ-001 WIDTH, default 64, counter width per channel in bits (>=2).
REQ-002 NCH, default 2, number of counter channels (>=2).
REQ-003 PSW, default 3, prescale divisor width in bits (>=1).
REQ-004 SAT, default 0, overflow mode: 0 = wrap to zero, 1 = saturate at all-ones.
REQ-005 SW = clog2(NCH), select width, derived parameter, not overridable.

Interface
REQ-006 Clk  in  1  clock; all state changes on rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 En  in  1  event strobe; one event per cycle when high.
REQ-009 Sel  in  SW  channel receiving the event when En=1.
REQ-010 Clr  in  NCH  per-channel synchronous clear, bit c clears channel c.
REQ-011 CfgWe  in  1  divisor write strobe.
REQ-012 CfgCh  in  SW  channel addressed by the divisor write.
REQ-013 CfgDiv  in  PSW  divisor value D written to channel CfgCh.
REQ-014 Count  out  NCH*WIDTH  registered counts, channel c at bits [c*WIDTH +: WIDTH].
REQ-015 Tick  out  NCH  registered one-cycle pulse, bit c high in the cycle after channel c's count is incremented.
REQ-016 Ovf  out  NCH  sticky overflow flag per channel.

Function
REQ-017 Each channel SHALL hold a PSW-bit prescaler pre[c], a divisor div[c], a WIDTH-bit count and a sticky Ovf bit.
REQ-018 An event for channel c occurs when En=1, Sel=c, Sel<NCH, Reset=0 and Clr[c]=0.
REQ-019 On an event, if pre[c]==div[c] the count SHALL increment and pre[c] SHALL reset to 0; otherwise pre[c] SHALL increment and the count SHALL hold.
REQ-020 Divisor D therefore SHALL give one count increment per D+1 events; D=0 increments on every event; D=all-ones gives 2^PSW events per increment.
REQ-021 Count, Tick and Ovf SHALL reflect an event on the next rising edge (1-cycle latency); no combinational path from inputs to outputs.
REQ-022 Tick[c] SHALL be high for exactly one cycle per increment; it SHALL not pulse on prescaler-only events.
REQ-023 Increment at count all-ones with SAT=0 SHALL set count to 0 and Ovf[c] to 1; Tick[c] pulses.
REQ-024 Increment at count all-ones with SAT=1 SHALL hold count at all-ones and set Ovf[c] to 1; Tick[c] pulses.
REQ-025 Ovf[c] SHALL remain 1 until Reset or Clr[c].
REQ-026 Sel>=NCH (when NCH is not a power of two) SHALL be ignored: no state change in any channel.
REQ-027 Clr[c]=1 SHALL set count, pre[c] and Ovf[c] of channel c to 0 and suppress Tick[c]; div[c] SHALL be kept; Clr wins over a same-cycle event.
REQ-028 CfgWe=1 with CfgCh<NCH SHALL load div[CfgCh]=CfgDiv and set pre[CfgCh]=0; CfgCh>=NCH SHALL be ignored.
REQ-029 A same-cycle event on the configured channel SHALL be evaluated against the old divisor and old pre, after which pre SHALL be 0 and the new divisor SHALL apply from the next event; Clr of that channel in the same cycle still zeroes count and Ovf.
REQ-030 Channels SHALL be fully independent; an event, clear or write on one channel SHALL not change another.
REQ-031 En=0 SHALL leave all counts and prescalers unchanged; Clr and CfgWe still act.

Reset
REQ-032 Reset=1 at a rising edge SHALL set every count, pre, div, Tick and Ovf to 0, overriding En, Clr and CfgWe.
REQ-033 Reset mid-prescale SHALL discard partial prescaler progress; first post-reset event uses D=0.
REQ-034 Initial (pre-reset) register values SHALL be 0 in simulation.

Verification (NCH=2, WIDTH=8, PSW=3 unless stated)
REQ-035 Reset, En=1 Sel=0 for 5 cycles -> Count ch0 = 5 one cycle after last event, Tick[0] pulsed 5 times, ch1 = 0.
REQ-036 Write D=3 to ch1, 8 events on ch1 -> ch1 count 2, Tick[1] after 4th and 8th event only.
REQ-037 SAT=0, ch0 driven to 255 then 1 event -> count 0, Ovf[0]=1; SAT=1 same stimulus -> count 255, Ovf[0]=1, Tick[0] pulses.
REQ-038 Ch1 D=3, 2 events, then Clr[1] with same-cycle event -> count 0, pre 0, Ovf 0; next 4 events -> count 1.
REQ-039 Ch0 D=3 with pre=2, CfgWe D=1 with same-cycle ch0 event -> no increment, pre 0; next 2 events -> count +1.
REQ-040 NCH=3: Sel=3 with En=1 for 10 cycles -> all counts, Tick, Ovf unchanged; Reset mid-stream -> all outputs 0 next cycle.
